// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin arbiter sharing one ALU
//
// alu_share_arb
//   Time-shares a single ALU between two valid/ready requesters. At most one
//   operation is accepted per cycle. The result is captured in a response
//   register owned by that requester, and the register holds while that
//   requester applies backpressure.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     reqX_valid / reqX_ready    request handshake (ready is combinational)
//     reqX_A, reqX_B, reqX_Cin   operands and adder carry-in
//     reqX_Op, reqX_invA,
//     reqX_invB, reqX_sign       ALU controls
//     rspX_valid / rspX_ready    response handshake
//     rspX_out, rspX_zero,
//     rspX_ofl                   captured ALU result and flags
//
// alu
//   Combinational ALU.
//   Op 000 rotate left, 001 shift left, 010 shift right arithmetic,
//   011 shift right logical, 100 add, 101 and, 110 or, 111 xor.
//   The shift amount is the low log2(N) bits of the (optionally inverted) B.
//   Ports:
//     a_i, b_i, cin_i, op_i           operands, carry-in, opcode
//     inv_a_i, inv_b_i, sign_i        operand inversion, signed overflow
//     out_o, zero_o, ofl_o            result, result==0, overflow/carry

module alu #(
   parameter int N = 16,
   parameter int O = 3
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   input  logic [O-1:0] op_i,
   input  logic         inv_a_i,
   input  logic         inv_b_i,
   input  logic         sign_i,
   output logic [N-1:0] out_o,
   output logic         zero_o,
   output logic         ofl_o
);
   localparam int SW = $clog2(N);

   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic [SW-1:0]  sh;
   logic [2*N-1:0] rot;
   logic [N:0]     sum;
   logic [N-1:0]   sra;

   assign a   = inv_a_i ? ~a_i : a_i;
   assign b   = inv_b_i ? ~b_i : b_i;
   assign sh  = b[SW-1:0];
   // Rotate by shifting a doubled copy; the upper half is the rotated word.
   assign rot = {a, a} << sh;
   assign sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin_i};
   assign sra = $signed(a) >>> sh;

   always_comb begin
      out_o = '0;
      ofl_o = 1'b0;
      case (op_i[2:0])
         3'b000: out_o = rot[2*N-1:N];
         3'b001: out_o = a << sh;
         3'b010: out_o = sra;
         3'b011: out_o = a >> sh;
         3'b100: begin
            out_o = sum[N-1:0];
            // Signed overflow: equal operand signs, result sign differs.
            // Unsigned overflow: carry out of the top bit.
            ofl_o = sign_i ? ((a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]))
                           : sum[N];
         end
         3'b101: out_o = a & b;
         3'b110: out_o = a | b;
         default: out_o = a ^ b;
      endcase
   end

   assign zero_o = (out_o == '0);
endmodule

module alu_share_arb #(
   parameter int N = 16,
   parameter int O = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_A,
   input  logic [N-1:0] req0_B,
   input  logic         req0_Cin,
   input  logic [O-1:0] req0_Op,
   input  logic         req0_invA,
   input  logic         req0_invB,
   input  logic         req0_sign,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_A,
   input  logic [N-1:0] req1_B,
   input  logic         req1_Cin,
   input  logic [O-1:0] req1_Op,
   input  logic         req1_invA,
   input  logic         req1_invB,
   input  logic         req1_sign,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [N-1:0] rsp0_out,
   output logic         rsp0_zero,
   output logic         rsp0_ofl,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [N-1:0] rsp1_out,
   output logic         rsp1_zero,
   output logic         rsp1_ofl
);
   logic         elig0, elig1;
   logic         gnt0, gnt1;
   logic [N-1:0] alu_a, alu_b, alu_out;
   logic         alu_cin, alu_inv_a, alu_inv_b, alu_sign, alu_zero, alu_ofl;
   logic [O-1:0] alu_op;

   // last_grant_q: 0 = requester 0 won last, 1 = requester 1 won last.
   logic         last_grant_q, last_grant_d;
   logic         rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [N-1:0] rsp0_out_q, rsp0_out_d, rsp1_out_q, rsp1_out_d;
   logic         rsp0_zero_q, rsp0_zero_d, rsp1_zero_q, rsp1_zero_d;
   logic         rsp0_ofl_q, rsp0_ofl_d, rsp1_ofl_q, rsp1_ofl_d;

   // A slot being drained this cycle counts as free, so a streaming
   // requester sees no bubble.
   assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
   assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

   assign gnt0 = elig0 && (!elig1 || last_grant_q);
   assign gnt1 = elig1 && (!elig0 || !last_grant_q);

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Requester 0 is the default mux leg; with no grant the result is unused.
   assign alu_a     = gnt1 ? req1_A    : req0_A;
   assign alu_b     = gnt1 ? req1_B    : req0_B;
   assign alu_cin   = gnt1 ? req1_Cin  : req0_Cin;
   assign alu_op    = gnt1 ? req1_Op   : req0_Op;
   assign alu_inv_a = gnt1 ? req1_invA : req0_invA;
   assign alu_inv_b = gnt1 ? req1_invB : req0_invB;
   assign alu_sign  = gnt1 ? req1_sign : req0_sign;

   alu #(.N(N), .O(O)) u_alu (
      .a_i     (alu_a),
      .b_i     (alu_b),
      .cin_i   (alu_cin),
      .op_i    (alu_op),
      .inv_a_i (alu_inv_a),
      .inv_b_i (alu_inv_b),
      .sign_i  (alu_sign),
      .out_o   (alu_out),
      .zero_o  (alu_zero),
      .ofl_o   (alu_ofl)
   );

   always_comb begin
      rsp0_valid_d = rsp0_valid_q;
      rsp0_out_d   = rsp0_out_q;
      rsp0_zero_d  = rsp0_zero_q;
      rsp0_ofl_d   = rsp0_ofl_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_out_d   = rsp1_out_q;
      rsp1_zero_d  = rsp1_zero_q;
      rsp1_ofl_d   = rsp1_ofl_q;
      last_grant_d = last_grant_q;

      if (gnt0) begin
         rsp0_valid_d = 1'b1;
         rsp0_out_d   = alu_out;
         rsp0_zero_d  = alu_zero;
         rsp0_ofl_d   = alu_ofl;
         last_grant_d = 1'b0;
      end else if (rsp0_ready) begin
         rsp0_valid_d = 1'b0;
      end

      if (gnt1) begin
         rsp1_valid_d = 1'b1;
         rsp1_out_d   = alu_out;
         rsp1_zero_d  = alu_zero;
         rsp1_ofl_d   = alu_ofl;
         last_grant_d = 1'b1;
      end else if (rsp1_ready) begin
         rsp1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid_q <= 1'b0;
         rsp0_out_q   <= '0;
         rsp0_zero_q  <= 1'b0;
         rsp0_ofl_q   <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_out_q   <= '0;
         rsp1_zero_q  <= 1'b0;
         rsp1_ofl_q   <= 1'b0;
         // Pretend requester 1 won last so requester 0 takes the first conflict.
         last_grant_q <= 1'b1;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_out_q   <= rsp0_out_d;
         rsp0_zero_q  <= rsp0_zero_d;
         rsp0_ofl_q   <= rsp0_ofl_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_out_q   <= rsp1_out_d;
         rsp1_zero_q  <= rsp1_zero_d;
         rsp1_ofl_q   <= rsp1_ofl_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_out   = rsp0_out_q;
   assign rsp0_zero  = rsp0_zero_q;
   assign rsp0_ofl   = rsp0_ofl_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_out   = rsp1_out_q;
   assign rsp1_zero  = rsp1_zero_q;
   assign rsp1_ofl   = rsp1_ofl_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb

module tb_alu_share_arb;
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [2:0]  op;
      logic        ia;
      logic        ib;
      logic        sg;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   req_t  r0, r1;
   logic  v0, v1, rr0, rr1;
   logic  req0_ready, req1_ready;
   logic  rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, rsp0_ofl, rsp1_ofl;
   logic [15:0] rsp0_out, rsp1_out;

   int vectors = 0;
   int fails = 0;
   logic [17:0] sb0[$];
   logic [17:0] sb1[$];
   logic [17:0] e0, e1;
   req_t  p0, p1;
   logic  pend0 = 1'b0, pend1 = 1'b0;

   alu_share_arb #(.N(16), .O(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0),
      .req0_ready (req0_ready),
      .req0_A     (r0.a),
      .req0_B     (r0.b),
      .req0_Cin   (r0.cin),
      .req0_Op    (r0.op),
      .req0_invA  (r0.ia),
      .req0_invB  (r0.ib),
      .req0_sign  (r0.sg),
      .req1_valid (v1),
      .req1_ready (req1_ready),
      .req1_A     (r1.a),
      .req1_B     (r1.b),
      .req1_Cin   (r1.cin),
      .req1_Op    (r1.op),
      .req1_invA  (r1.ia),
      .req1_invB  (r1.ib),
      .req1_sign  (r1.sg),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rr0),
      .rsp0_out   (rsp0_out),
      .rsp0_zero  (rsp0_zero),
      .rsp0_ofl   (rsp0_ofl),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rr1),
      .rsp1_out   (rsp1_out),
      .rsp1_zero  (rsp1_zero),
      .rsp1_ofl   (rsp1_ofl)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference result {zero, ofl, out}, built bit-serially / with integers.
   function automatic logic [17:0] model(input req_t r);
      logic [15:0] a, b, o;
      logic [16:0] u;
      logic        of;
      int          s, sh;
      a  = r.ia ? ~r.a : r.a;
      b  = r.ib ? ~r.b : r.b;
      sh = int'(b[3:0]);
      o  = a;
      of = 1'b0;
      case (r.op)
         3'd0: for (int i = 0; i < sh; i++) o = {o[14:0], o[15]};
         3'd1: for (int i = 0; i < sh; i++) o = {o[14:0], 1'b0};
         3'd2: for (int i = 0; i < sh; i++) o = {o[15], o[15:1]};
         3'd3: for (int i = 0; i < sh; i++) o = {1'b0, o[15:1]};
         3'd4: begin
            u = {1'b0, a} + {1'b0, b} + {16'd0, r.cin};
            o = u[15:0];
            if (r.sg) begin
               s  = int'($signed(a)) + int'($signed(b)) + int'(r.cin);
               of = (s > 32767) || (s < -32768);
            end else begin
               of = u[16];
            end
         end
         3'd5: o = a & b;
         3'd6: o = a | b;
         default: o = a ^ b;
      endcase
      return {(o == 16'd0), of, o};
   endfunction

   // Scoreboard: push on grant, pop when the held result is consumed.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp0_valid && rr0) begin
            if (sb0.size() == 0) chk("sb0_extra", 1, 0);
            else begin
               e0 = sb0.pop_front();
               chk("rsp0", {14'd0, rsp0_zero, rsp0_ofl, rsp0_out}, {14'd0, e0});
            end
         end
         if (rsp1_valid && rr1) begin
            if (sb1.size() == 0) chk("sb1_extra", 1, 0);
            else begin
               e1 = sb1.pop_front();
               chk("rsp1", {14'd0, rsp1_zero, rsp1_ofl, rsp1_out}, {14'd0, e1});
            end
         end
         if (req0_ready) sb0.push_back(model(r0));
         if (req1_ready) sb1.push_back(model(r1));
         if (pend0 && v0) assert (r0 == p0) else $error("requester 0 changed while stalled");
         if (pend1 && v1) assert (r1 == p1) else $error("requester 1 changed while stalled");
         pend0 = v0 && !req0_ready;
         pend1 = v1 && !req1_ready;
         p0 = r0;
         p1 = r1;
      end
   end

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_post();
      @(posedge clk);
      #1;
   endtask

   req_t rt0[4], rt1[3], bt[5];
   int   i0, i1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      r0 = '0; r1 = '0; v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
      rt0[0] = '{16'h1234, 16'h0004, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      rt0[1] = '{16'h8001, 16'h0001, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
      rt0[2] = '{16'h00F0, 16'h0000, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0};
      rt0[3] = '{16'h4000, 16'h4000, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
      rt1[0] = '{16'h0003, 16'h0002, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
      rt1[1] = '{16'hF000, 16'h0004, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      rt1[2] = '{16'h7FFF, 16'h0001, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1};
      bt[0]  = '{16'h0001, 16'h0002, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
      bt[1]  = '{16'hFF00, 16'h0F0F, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
      bt[2]  = '{16'h0000, 16'h0000, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
      bt[3]  = '{16'hAAAA, 16'h5555, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
      bt[4]  = '{16'h0001, 16'h0001, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0};

      #2 rst_n = 0;
      repeat (2) to_neg();
      chk("rst0_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst0_d0", {rsp0_zero, rsp0_ofl, rsp0_out}, 0);
      chk("rst0_d1", {rsp1_zero, rsp1_ofl, rsp1_out}, 0);
      to_post();
      rst_n = 1;

      // Single signed add on requester 0, result held (rsp0_ready low).
      r0 = '{16'h7FFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1};
      v0 = 1;
      to_neg();
      chk("add_rdy", {req0_ready, req1_ready}, 2'b10);
      to_post();
      v0 = 0;
      chk("add_valid", rsp0_valid, 1);
      chk("add_res", {rsp0_zero, rsp0_ofl, rsp0_out}, 18'h18000);
      to_neg();
      to_post();
      chk("add_hold", {rsp0_valid, rsp0_zero, rsp0_ofl, rsp0_out}, 19'h58000);

      // Mid-cycle asynchronous reset discards the held result.
      #2 rst_n = 0;
      #1;
      chk("rst_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_d0", {rsp0_zero, rsp0_ofl, rsp0_out}, 0);
      chk("rst_d1", {rsp1_zero, rsp1_ofl, rsp1_out}, 0);
      sb0.delete();
      sb1.delete();
      to_post();
      rst_n = 1; rr0 = 1; rr1 = 1;

      // Round-robin: first conflict after reset goes to requester 0.
      i0 = 0; i1 = 0;
      r0 = rt0[0]; r1 = rt1[0]; v0 = 1; v1 = 1;
      for (int i = 0; i < 6; i++) begin
         to_neg();
         chk("rr_gnt", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         to_post();
         if (i % 2 == 0) begin
            i0++;
            r0 = rt0[i0];
         end else begin
            i1++;
            if (i1 < 3) r1 = rt1[i1];
         end
      end
      v0 = 0; v1 = 0;
      to_neg();
      to_post();

      // Unsigned wrap, then xor to zero, on requester 1.
      r1 = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0};
      v1 = 1;
      to_neg();
      chk("wrap_rdy", {req0_ready, req1_ready}, 2'b01);
      to_post();
      chk("wrap_res", {rsp1_valid, rsp1_zero, rsp1_ofl, rsp1_out}, 19'h70000);
      r1 = '{16'hA5A5, 16'hA5A5, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
      to_neg();
      chk("xor_rdy", {req0_ready, req1_ready}, 2'b01);
      to_post();
      v1 = 0;
      chk("xor_res", {rsp1_valid, rsp1_zero, rsp1_ofl, rsp1_out}, 19'h60000);

      // Backpressure on requester 0.
      rr0 = 0;
      r0 = '{16'h1234, 16'h0F00, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0};
      v0 = 1;
      to_neg();
      chk("bp_fill_rdy", {req0_ready, req1_ready}, 2'b10);
      to_post();
      chk("bp_fill", {rsp0_valid, rsp0_zero, rsp0_ofl, rsp0_out}, 19'h41F34);
      r0 = '{16'h0010, 16'h0003, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0};
      r1 = bt[0]; v1 = 1;
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("bp_gnt", {req0_ready, req1_ready}, 2'b01);
         to_post();
         chk("bp_hold", {rsp0_valid, rsp0_zero, rsp0_ofl, rsp0_out}, 19'h41F34);
         r1 = bt[i + 1];
      end
      rr0 = 1;
      to_neg();
      chk("bp_rel0", {req0_ready, req1_ready}, 2'b10);
      to_post();
      r0 = '{16'h8000, 16'h0001, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0};
      to_neg();
      chk("bp_rel1", {req0_ready, req1_ready}, 2'b01);
      to_post();
      r1 = bt[4];
      to_neg();
      chk("bp_rel2", {req0_ready, req1_ready}, 2'b10);
      to_post();
      v0 = 0; v1 = 0;
      to_neg();
      to_post();

      // Same-cycle drain and refill on requester 0.
      rr0 = 0;
      r0 = '{16'h1111, 16'h2222, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
      v0 = 1;
      to_neg();
      chk("dr_fill_rdy", {req0_ready, req1_ready}, 2'b10);
      to_post();
      chk("dr_fill", {rsp0_valid, rsp0_zero, rsp0_ofl, rsp0_out}, 19'h43333);
      rr0 = 1;
      r0 = '{16'h00FF, 16'h0F0F, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0};
      to_neg();
      chk("dr_rdy", {req0_ready, req1_ready, rsp0_valid}, 3'b101);
      to_post();
      v0 = 0;
      chk("dr_res", {rsp0_valid, rsp0_zero, rsp0_ofl, rsp0_out}, 19'h4000F);

      repeat (3) begin
         to_neg();
         to_post();
      end
      chk("sb0_left", sb0.size(), 0);
      chk("sb1_left", sb1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares a single `alu` instance between two requesters, for example the execute stage and an address/branch-compare unit. It accepts one operation per cycle through valid/ready request ports and grants conflicts round-robin. Each result goes to a per-requester response register that is held under backpressure.

## Interface
- `N`, default 16: operand/result width.
- `O`, default 3: ALU opcode width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_ready`, `req1_ready` out 1: request granted this cycle. Combinational.
- `reqX_A`, `reqX_B` in N: operands.
- `reqX_Cin` in 1: adder carry-in.
- `reqX_Op` in O: ALU opcode.
  - 0xx: shift/rotate.
  - 100: add.
  - 101: and.
  - 110: or.
  - 111: xor.
- `reqX_invA`, `reqX_invB`, `reqX_sign` in 1: passed to the ALU.
- `rsp0_valid`, `rsp1_valid` out 1: result held for that requester.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes the result.
- `rspX_out` out N: captured ALU `Out`.
- `rspX_zero`, `rspX_ofl` out 1: captured ALU `Zero` and `Ofl`.

## Operation
- Exactly one `alu` is instantiated internally. Its inputs are muxed from the granted requester. When there is no grant, the mux selects requester 0 and the ALU output is ignored.
- Eligibility of requester X: `reqX_valid` AND (`rspX_valid`=0 OR `rspX_ready`=1). A full slot that is drained in the same cycle counts as free.
- Grant:
  - No eligible requester: no grant.
  - One eligible requester: grant it.
  - Both eligible: grant the requester opposite to `last_grant`.
- `reqX_ready` = grant X. At most one ready is high per cycle.
- On a clock edge where X is granted:
  - `rspX_out`, `rspX_zero` and `rspX_ofl` load the ALU outputs.
  - `rspX_valid` is set to 1.
  - `last_grant` is set to X.
- On a clock edge where `rspX_valid` & `rspX_ready` and X is not granted: `rspX_valid` is cleared to 0, and the data registers keep their values.
- `last_grant` changes only when a grant occurs.
- While `rspX_valid`=1 and `rspX_ready`=0, `rspX_out`, `rspX_zero` and `rspX_ofl` are held stable.
- Requester obligation: operands and controls stay stable while `valid`=1 and `ready`=0. The bench asserts this.
- `reqX_valid` may drop without ever being granted. This is legal; there is no pending state.

## Timing
- Reset (`rst_n` low, asynchronous and immediate):
  - `rsp0_valid` = `rsp1_valid` = 0.
  - All `rspX_out` = 0; `rspX_zero` = 0; `rspX_ofl` = 0.
  - `last_grant` = 1, so requester 0 wins the first conflict.
  - Any in-flight or held results are discarded.
- Ready is combinational from the request valids, response state and `rspX_ready`. There is no path from the ALU result to ready.
- Latency: the request is accepted at edge k and `rspX_valid` is 1 after edge k, i.e. one cycle.
- Throughput: one ALU operation per cycle in total.
  - A single requester with `rsp_ready` held high gets back-to-back operations.
  - Two continuously valid requesters alternate 0,1,0,1.
- Simultaneous drain and new grant on the same slot: the new result overwrites and `valid` stays 1, so there is no bubble.
- Starvation bound: a continuously valid, eligible requester is granted within 2 cycles.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle with `rsp0_valid`=1 -> `rsp0_valid`, `rsp1_valid`, `rspX_out`, `rspX_zero` and `rspX_ofl` all read 0 immediately. After release, the first conflict grants requester 0.
- Single add on requester 0: A=16'h7FFF, B=16'h0001, Op=100, sign=1, Cin=0 -> `req0_ready`=1 in the same cycle; the next cycle shows `rsp0_valid`=1, `rsp0_out`=16'h8000, `rsp0_ofl`=1, `rsp0_zero`=0.
- Unsigned wrap and zero flag:
  - Requester 1, A=16'hFFFF, B=16'h0001, Op=100, sign=0 -> `rsp1_out`=16'h0000, `rsp1_ofl`=1, `rsp1_zero`=1.
  - Then xor with A=B=16'hA5A5 -> `rsp1_out`=0, `rsp1_zero`=1, `rsp1_ofl`=0.
- Round-robin: both requesters valid for 6 cycles, both `rsp_ready`=1, with distinct operations -> grant sequence 0,1,0,1,0,1, and each response matches its own operation one cycle later.
- Backpressure:
  - Setup: `rsp0_valid`=1 with `rsp0_ready`=0, `req0_valid`=1, `req1_valid`=1.
  - Required: `req0_ready`=0 and `rsp0_out` stays stable for 3 cycles, while requester 1 is granted every cycle.
  - Raising `rsp0_ready` makes requester 0 eligible in that same cycle; it then alternates with requester 1.
- Same-cycle drain and refill:
  - Setup: `rsp0_valid`=1, `rsp0_ready`=1, req0 and = A 16'h00FF, B 16'h0F0F, requester 1 idle.
  - Required: granted that cycle; the next cycle shows `rsp0_valid`=1 with `rsp0_out`=16'h000F and no intervening 0.
